// File: rtl/icache_responder.sv
// Direct-mapped, one-word-per-frame instruction cache answering the datapath
// fetch port with zero-latency hits and single-outstanding memory fills.
module icache_responder #(
    parameter int SETS  = 16,
    parameter int IDX_W = 4,
    parameter int TAG_W = 26
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    typedef enum logic {
        IDLE,
        FETCH
    } state_t;

    state_t            state_reg;
    logic [31:0]       miss_addr_reg;
    logic [31:0]       hit_count_reg;
    logic [31:0]       miss_count_reg;

    logic              valid_reg [SETS];
    logic [TAG_W-1:0]  tag_mem   [SETS];
    logic [31:0]       data_mem  [SETS];

    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]  fill_tag;
    logic              lookup_hit;
    logic              lookup_miss;
    logic              fetching;
    logic              fill_en;
    logic              addr_unused;

    assign req_idx     = imemaddr[IDX_W+1:2];
    assign req_tag     = imemaddr[31:IDX_W+2];
    assign fill_idx    = miss_addr_reg[IDX_W+1:2];
    assign fill_tag    = miss_addr_reg[31:IDX_W+2];
    assign addr_unused = ^imemaddr[1:0];

    assign fetching    = (state_reg == FETCH);
    assign fill_en     = fetching && !iwait;

    // Lookup is only meaningful in IDLE; a FETCH cycle never reports a hit.
    assign lookup_hit  = (state_reg == IDLE) && imemREN && valid_reg[req_idx]
                         && (tag_mem[req_idx] == req_tag);
    assign lookup_miss = (state_reg == IDLE) && imemREN && !lookup_hit;

    assign ihit       = lookup_hit;
    assign imemload   = lookup_hit ? data_mem[req_idx] : 32'h0;
    assign iREN       = fetching;
    assign iaddr      = fetching ? miss_addr_reg : 32'h0;
    assign hit_count  = hit_count_reg;
    assign miss_count = miss_count_reg;

    // Valid bits are the only frame state cleared by reset, so a fill
    // interrupted by reset leaves its frame invalid.
    generate
        for (genvar gi = 0; gi < SETS; gi++) begin : g_valid
            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    valid_reg[gi] <= 1'b0;
                end else if (fill_en && (fill_idx == IDX_W'(gi))) begin
                    valid_reg[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (fill_en) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= iload;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg      <= IDLE;
            miss_addr_reg  <= 32'h0;
            hit_count_reg  <= 32'h0;
            miss_count_reg <= 32'h0;
        end else begin
            if (lookup_hit) begin
                hit_count_reg <= hit_count_reg + 32'd1;
            end
            case (state_reg)
                IDLE: begin
                    if (lookup_miss) begin
                        miss_addr_reg  <= {imemaddr[31:2], 2'b00};
                        miss_count_reg <= miss_count_reg + 32'd1;
                        state_reg      <= FETCH;
                    end
                end
                FETCH: begin
                    // The fill targets the latched address even if the
                    // datapath has since moved on.
                    if (!iwait) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_responder.sv
// Directed bench for icache_responder: inputs change on the falling edge and
// outputs are checked 1 time unit later, away from the rising edge.
module tb_icache_responder;

    logic        CLK;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int checks;
    int errors;

    icache_responder #(.SETS(16), .IDX_W(4), .TAG_W(26)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .ihit       (ihit),
        .imemload   (imemload),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .iwait      (iwait),
        .iload      (iload),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Stimulus only: detect cycle, one FETCH cycle with data, back to IDLE.
    task automatic do_fill(input logic [31:0] addr, input logic [31:0] data);
        @(negedge CLK);
        imemREN = 1'b1; imemaddr = addr; iwait = 1'b1;
        @(negedge CLK);
        iwait = 1'b0; iload = data;
        @(negedge CLK);
        iwait = 1'b1; imemREN = 1'b0;
    endtask

    task automatic test_reset;
        nRST = 1'b0; imemREN = 1'b0; imemaddr = 32'h0; iwait = 1'b1; iload = 32'h0;
        @(negedge CLK); #1;
        checks++;
        if (ihit !== 1'b0 || iREN !== 1'b0 || iaddr !== 32'h0 || imemload !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: ihit=%b iREN=%b iaddr=%h imemload=%h, required 0/0/0/0",
                     ihit, iREN, iaddr, imemload);
        end
        checks++;
        if (hit_count !== 32'h0 || miss_count !== 32'h0) begin
            errors++;
            $display("FAIL reset_counters: hit=%0d miss=%0d, required 0/0", hit_count, miss_count);
        end
        @(negedge CLK);
        nRST = 1'b1;
        $display("reset: done");
    endtask

    task automatic test_cold_miss;
        @(negedge CLK);
        imemREN = 1'b1; imemaddr = 32'h0; iwait = 1'b1;
        #1;
        checks++;
        if (ihit !== 1'b0 || iREN !== 1'b0) begin
            errors++;
            $display("FAIL cold_detect: ihit=%b iREN=%b, required 0/0", ihit, iREN);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            if (i == 2) begin
                iwait = 1'b0; iload = 32'h20010005;
            end
            #1;
            checks++;
            if (iREN !== 1'b1 || iaddr !== 32'h0 || ihit !== 1'b0 || miss_count !== 32'd1) begin
                errors++;
                $display("FAIL cold_fetch%0d: iREN=%b iaddr=%h ihit=%b miss=%0d, required 1/0/0/1",
                         i, iREN, iaddr, ihit, miss_count);
            end
        end
        @(negedge CLK);
        iwait = 1'b1;
        #1;
        checks++;
        if (ihit !== 1'b1 || imemload !== 32'h20010005 || iREN !== 1'b0 || hit_count !== 32'd0) begin
            errors++;
            $display("FAIL cold_hit: ihit=%b imemload=%h iREN=%b hit=%0d, required 1/20010005/0/0",
                     ihit, imemload, iREN, hit_count);
        end
        @(negedge CLK);
        imemREN = 1'b0;
        #1;
        checks++;
        if (hit_count !== 32'd1 || miss_count !== 32'd1 || ihit !== 1'b0) begin
            errors++;
            $display("FAIL cold_counts: hit=%0d miss=%0d ihit=%b, required 1/1/0",
                     hit_count, miss_count, ihit);
        end
        $display("cold_miss: addr=00000000 data=20010005");
    endtask

    task automatic test_reaccess;
        @(negedge CLK);
        imemREN = 1'b1; imemaddr = 32'h0;
        #1;
        checks++;
        if (ihit !== 1'b1 || imemload !== 32'h20010005 || iREN !== 1'b0) begin
            errors++;
            $display("FAIL reaccess_hit: ihit=%b imemload=%h iREN=%b, required 1/20010005/0",
                     ihit, imemload, iREN);
        end
        @(negedge CLK);
        imemREN = 1'b0;
        #1;
        checks++;
        if (hit_count !== 32'd2 || miss_count !== 32'd1 || iREN !== 1'b0) begin
            errors++;
            $display("FAIL reaccess_counts: hit=%0d miss=%0d iREN=%b, required 2/1/0",
                     hit_count, miss_count, iREN);
        end
        $display("reaccess: addr=00000000 hit");
    endtask

    task automatic test_conflict;
        do_fill(32'h40, 32'hAAAA0000);
        @(negedge CLK);
        imemREN = 1'b1; imemaddr = 32'h40;
        #1;
        checks++;
        if (ihit !== 1'b1 || imemload !== 32'hAAAA0000) begin
            errors++;
            $display("FAIL conflict_new_hit: ihit=%b imemload=%h, required 1/aaaa0000", ihit, imemload);
        end
        @(negedge CLK);
        imemaddr = 32'h0;
        #1;
        checks++;
        if (ihit !== 1'b0 || iREN !== 1'b0) begin
            errors++;
            $display("FAIL conflict_old_miss: ihit=%b iREN=%b, required 0/0", ihit, iREN);
        end
        // Datapath drops the request; the fill must still finish.
        @(negedge CLK);
        imemREN = 1'b0; iwait = 1'b0; iload = 32'h20010005;
        #1;
        checks++;
        if (iREN !== 1'b1 || iaddr !== 32'h0 || miss_count !== 32'd3 || hit_count !== 32'd3) begin
            errors++;
            $display("FAIL conflict_fetch: iREN=%b iaddr=%h miss=%0d hit=%0d, required 1/0/3/3",
                     iREN, iaddr, miss_count, hit_count);
        end
        @(negedge CLK);
        iwait = 1'b1;
        #1;
        checks++;
        if (iREN !== 1'b0 || ihit !== 1'b0) begin
            errors++;
            $display("FAIL conflict_done: iREN=%b ihit=%b, required 0/0", iREN, ihit);
        end
        $display("conflict: 00000040 evicted by 00000000");
    endtask

    task automatic test_idle;
        logic [31:0] addrs [10];
        addrs = '{32'h0, 32'h40, 32'h4, 32'h8, 32'hFFFFFFFC,
                  32'h10, 32'h3C, 32'h80000000, 32'h44, 32'h0};
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            imemREN = 1'b0; imemaddr = addrs[i];
            #1;
            checks++;
            if (ihit !== 1'b0 || iREN !== 1'b0 || hit_count !== 32'd3 || miss_count !== 32'd3) begin
                errors++;
                $display("FAIL idle%0d: ihit=%b iREN=%b hit=%0d miss=%0d, required 0/0/3/3",
                         i, ihit, iREN, hit_count, miss_count);
            end
        end
        $display("idle: 10 cycles without request");
    endtask

    task automatic test_reset_mid_fill;
        @(negedge CLK);
        imemREN = 1'b1; imemaddr = 32'h10; iwait = 1'b1;
        @(negedge CLK);
        #1;
        checks++;
        if (iREN !== 1'b1 || iaddr !== 32'h10) begin
            errors++;
            $display("FAIL rstfill_fetch: iREN=%b iaddr=%h, required 1/00000010", iREN, iaddr);
        end
        #2;
        nRST = 1'b0;
        #1;
        checks++;
        if (iREN !== 1'b0 || iaddr !== 32'h0 || hit_count !== 32'h0 || miss_count !== 32'h0) begin
            errors++;
            $display("FAIL rstfill_async: iREN=%b iaddr=%h hit=%0d miss=%0d, required 0/0/0/0",
                     iREN, iaddr, hit_count, miss_count);
        end
        @(negedge CLK);
        nRST = 1'b1;
        #1;
        checks++;
        if (ihit !== 1'b0) begin
            errors++;
            $display("FAIL rstfill_invalid: ihit=%b, required 0", ihit);
        end
        @(negedge CLK);
        imemREN = 1'b0; iwait = 1'b0; iload = 32'h33333333;
        #1;
        checks++;
        if (iREN !== 1'b1 || iaddr !== 32'h10 || miss_count !== 32'd1) begin
            errors++;
            $display("FAIL rstfill_remiss: iREN=%b iaddr=%h miss=%0d, required 1/00000010/1",
                     iREN, iaddr, miss_count);
        end
        @(negedge CLK);
        iwait = 1'b1;
        $display("reset_mid_fill: 00000010 refetched");
    endtask

    task automatic test_addr_change;
        @(negedge CLK);
        imemREN = 1'b1; imemaddr = 32'h4; iwait = 1'b1;
        @(negedge CLK);
        imemaddr = 32'h8;
        #1;
        checks++;
        if (iREN !== 1'b1 || iaddr !== 32'h4 || ihit !== 1'b0) begin
            errors++;
            $display("FAIL addrchg_fetch0: iREN=%b iaddr=%h ihit=%b, required 1/00000004/0",
                     iREN, iaddr, ihit);
        end
        @(negedge CLK);
        iwait = 1'b0; iload = 32'h11111111;
        #1;
        checks++;
        if (iREN !== 1'b1 || iaddr !== 32'h4) begin
            errors++;
            $display("FAIL addrchg_fetch1: iREN=%b iaddr=%h, required 1/00000004", iREN, iaddr);
        end
        @(negedge CLK);
        iwait = 1'b1;
        #1;
        checks++;
        if (ihit !== 1'b0 || iREN !== 1'b0) begin
            errors++;
            $display("FAIL addrchg_newmiss: ihit=%b iREN=%b, required 0/0", ihit, iREN);
        end
        @(negedge CLK);
        iwait = 1'b0; iload = 32'h22222222;
        #1;
        checks++;
        if (iREN !== 1'b1 || iaddr !== 32'h8 || miss_count !== 32'd3) begin
            errors++;
            $display("FAIL addrchg_fetch8: iREN=%b iaddr=%h miss=%0d, required 1/00000008/3",
                     iREN, iaddr, miss_count);
        end
        @(negedge CLK);
        iwait = 1'b1; imemaddr = 32'h4;
        #1;
        checks++;
        if (ihit !== 1'b1 || imemload !== 32'h11111111) begin
            errors++;
            $display("FAIL addrchg_hit4: ihit=%b imemload=%h, required 1/11111111", ihit, imemload);
        end
        @(negedge CLK);
        imemaddr = 32'h8;
        #1;
        checks++;
        if (ihit !== 1'b1 || imemload !== 32'h22222222) begin
            errors++;
            $display("FAIL addrchg_hit8: ihit=%b imemload=%h, required 1/22222222", ihit, imemload);
        end
        @(negedge CLK);
        imemREN = 1'b0;
        #1;
        checks++;
        if (hit_count !== 32'd2 || miss_count !== 32'd3) begin
            errors++;
            $display("FAIL addrchg_counts: hit=%0d miss=%0d, required 2/3", hit_count, miss_count);
        end
        $display("addr_change: 00000004 filled, then 00000008");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_cold_miss();
        test_reaccess();
        test_conflict();
        test_idle();
        test_reset_mid_fill();
        test_addr_change();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/icache_responder.md
Name: icache_responder

Overview:
- Instruction-side responder for the datapath_cache_if instruction port.
- The pipelined datapath issues imemREN/imemaddr and advances PC only on ihit; this block answers those requests from a direct-mapped cache.
- On a miss it fetches the word from the memory controller over an iREN/iaddr/iwait/iload request port.
- Sits between the datapath IF stage and the memory controller arbiter.

Parameters:
- SETS, 16, number of one-word frames (power of 2).
- IDX_W, 4, log2(SETS), index bits.
- TAG_W, 26, equals 32-2-IDX_W.

Ports:
- CLK  input  1  clock, rising edge.
- nRST  input  1  reset, asynchronous, active-low.
- imemREN  input  1  datapath instruction read request.
- imemaddr  input  32  datapath instruction byte address, word aligned.
- ihit  output  1  request satisfied this cycle.
- imemload  output  32  instruction word, valid when ihit=1.
- iREN  output  1  memory read request.
- iaddr  output  32  memory read word address.
- iwait  input  1  memory busy; iwait=0 while iREN=1 means iload is valid this cycle.
- iload  input  32  memory read data.
- hit_count  output  32  number of hit cycles, wraps.
- miss_count  output  32  number of misses detected, wraps.

Behaviour:
- Address split: index = imemaddr[IDX_W+1:2]; tag = imemaddr[31:IDX_W+2]; bits [1:0] ignored.
- Frame storage per set: valid (1), tag (TAG_W), data (32).
- Reset (async, nRST=0):
  - all valid=0, state=IDLE, miss_addr=0, counters=0.
  - ihit=0, iREN=0, iaddr=0, imemload=0.
  - Tag/data storage need not be cleared.
- State IDLE:
  - hit = imemREN & valid[index] & (tag[index]==tag). If hit: ihit=1 and imemload=data[index], combinationally in the same cycle (zero-latency hit).
  - If not a hit: ihit=0, imemload=0.
  - imemREN=1 without a hit is a miss: latch miss_addr={imemaddr[31:2],2'b00}, next state FETCH, miss_count+1.
  - imemREN=0: stay IDLE, no counter change.
- State FETCH:
  - iREN=1, iaddr=miss_addr, ihit=0, imemload=0.
  - iwait=1: hold state and outputs.
  - iwait=0: on this clock edge write frame[miss_addr index] = {valid=1, tag=miss_addr tag, data=iload}, then next state IDLE.
- Outside FETCH, iREN=0 and iaddr=0.
- Miss timing: detect cycle, then at least 1 FETCH cycle, then the hit cycle. Minimum miss penalty is 2 cycles beyond a hit.
- hit_count increments on every clock edge where ihit=1. The datapath holds the address while stalled, so repeated hit cycles each count.
- Both counters wrap 0xFFFFFFFF to 0.
- Boundary conditions:
  - imemREN drops or imemaddr changes during FETCH: fill still completes to miss_addr, then return to IDLE and re-evaluate the new address.
  - Conflict fill (same index, different tag): overwrites the frame; the previous tag misses afterwards.
  - nRST asserted mid-FETCH: fill discarded, frame stays invalid, state IDLE immediately.
  - iwait held high indefinitely (memory servicing the data port): remain in FETCH with iREN=1; no timeout.
  - A hit never issues a memory request.
  - Only one outstanding fill at a time.
  - No write path and no invalidate input: the instruction side is read-only.

Test Plan:
- Cold miss: after reset, imemREN=1, imemaddr=0x00000000, memory iwait=1 for 2 cycles then iwait=0 with iload=0x20010005.
  - Required: ihit=0 in the detect cycle; iREN=1 and iaddr=0 for 3 cycles.
  - Next cycle: ihit=1, imemload=0x20010005, miss_count=1, hit_count=1 after that edge.
- Re-access 0x00000000 after the fill: ihit=1 in the same cycle, iREN stays 0, no miss_count change.
- Conflict: fill 0x00000040 (index 0, tag 1) with iload=0xAAAA0000.
  - Required: the 0x40 access then hits with 0xAAAA0000.
  - Access to 0x00000000 then misses: miss_count increments, iREN=1, iaddr=0x0.
- imemREN=0 with any address: ihit=0, iREN=0, both counters unchanged for 10 cycles.
- Reset mid-fill: miss on 0x00000010, pull nRST low during FETCH while iwait=1.
  - Required: iREN=0 immediately, counters=0.
  - After release, 0x10 misses again (frame was not validated).
- Address change during FETCH: miss on 0x4, switch imemaddr to 0x8 while iwait=1, then iwait=0 with iload=0x11111111.
  - Required: iaddr stays 0x4 throughout the fill.
  - After the fill, 0x8 misses; a later access to 0x4 hits with 0x11111111.
